// File: rtl/ps2_rx_frame_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 frame receiver.
//   ps2_state_e   - receiver FSM states
//   PS2_BREAK     - break (key release) prefix code
//   PS2_EXT       - extended-key prefix code (delivered unmodified)
//   PS2_DATA_BITS - payload bits per frame
//   odd_parity_ok - true when data plus parity bit carry an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if: PS/2 line inputs and decoded-code outputs of the receiver.
//   kbdclk, kbddat  - raw PS/2 lines (asynchronous, idle high)
//   keycode         - last accepted scan code (level)
//   code_valid      - one-cycle strobe, keycode updated this cycle
//   key_release     - qualifies code_valid when the break filter is built in
//   frame_err       - one-cycle strobe on parity, stop-bit or timeout failure
//   busy            - frame in progress
// Modports:
//   master - the receiver (samples the lines, drives the code outputs)
//   slave  - the device side / consumer (drives the lines, reads the codes)
interface ps2_rx_frame_if;

  logic       kbdclk;
  logic       kbddat;
  logic [7:0] keycode;
  logic       code_valid;
  logic       key_release;
  logic       frame_err;
  logic       busy;

  modport master (
    input  kbdclk,
    input  kbddat,
    output keycode,
    output code_valid,
    output key_release,
    output frame_err,
    output busy
  );

  modport slave (
    output kbdclk,
    output kbddat,
    input  keycode,
    input  code_valid,
    input  key_release,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/ps2_rx_frame_sync_filter.sv
// ps2_sync_filter: brings the PS/2 lines into the clk domain and cleans kbdclk.
//   clk, rst   - system clock, asynchronous active-high reset
//   kbdclk     - raw PS/2 clock
//   kbddat     - raw PS/2 data
//   clk_fall   - one-cycle strobe on each filtered kbdclk 1->0 transition
//   dat_sync   - synchronised kbddat, valid to sample while clk_fall is high
// The filtered clock level only changes after GLITCH_CYCLES consecutive
// synchronised samples disagree with it; any agreeing sample restarts the count.
module ps2_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic kbdclk,
  input  logic kbddat,
  output logic clk_fall,
  output logic dat_sync
);

  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GW-1:0] GLAST = GW'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic [GW-1:0]          gcnt;
  logic                   level;
  logic                   clk_s;
  logic                   differ;
  logic                   toggle;

  // Lines idle high, so the chains reset high to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sr <= '1;
      dat_sr <= '1;
    end else begin
      clk_sr <= {clk_sr[SYNC_STAGES-2:0], kbdclk};
      dat_sr <= {dat_sr[SYNC_STAGES-2:0], kbddat};
    end
  end

  assign clk_s  = clk_sr[SYNC_STAGES-1];
  assign differ = (clk_s != level);
  // Current disagreeing sample is the GLITCH_CYCLES-th in a row.
  assign toggle = differ && (gcnt == GLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt  <= '0;
      level <= 1'b1;
    end else if (!differ) begin
      gcnt <= '0;
    end else if (toggle) begin
      level <= ~level;
      gcnt  <= '0;
    end else begin
      gcnt <= gcnt + GW'(1);
    end
  end

  assign clk_fall = toggle && level;
  assign dat_sync = dat_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
//   clk, rst  - system clock, asynchronous active-high reset
//   bus       - ps2_rx_frame_if.master: kbdclk/kbddat in; keycode, code_valid,
//               key_release, frame_err, busy out
// Deframes start, 8 data bits LSB first, odd parity and stop; accepted codes
// update keycode with a code_valid strobe one cycle after the stop-bit edge.
// Bad parity/stop or a stalled frame produce a frame_err strobe instead.
// Build option PS2_BREAK_FILTER_EN: swallow 0xF0 break prefixes and flag the
// following code with key_release; undefined delivers 0xF0 as a normal code.
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | waiting for a falling edge with data low (start bit)
// DATA   | shifting in the 8 payload bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and parity, then back to IDLE
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  ps2_rx_frame_if.master        bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [BW-1:0] BLAST = BW'(PS2_DATA_BITS - 1);

  ps2_state_e               state_q, state_d;
  logic [PS2_DATA_BITS-1:0] sr;
  logic [BW-1:0]            bit_cnt;
  logic                     par_q;
  logic [TW-1:0]            tmr;

  logic fall;
  logic dat;
  logic timeout_c;
  logic stop_c;
  logic frame_good;
  logic accept_c;
  logic reject_c;

  logic [7:0] keycode_q;
  logic       code_valid_q;
  logic       key_release_q;
  logic       frame_err_q;

  ps2_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_sync_filter (
    .clk      (clk),
    .rst      (rst),
    .kbdclk   (bus.kbdclk),
    .kbddat   (bus.kbddat),
    .clk_fall (fall),
    .dat_sync (dat)
  );

  // Down-counter reloaded on every edge; terminal count mid-frame aborts.
  // A coincident edge wins over the timeout.
  assign timeout_c = (state_q != IDLE) && (tmr == '0) && !fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state_q)
        IDLE:    if (!dat) state_d = DATA;
        DATA:    if (bit_cnt == BLAST) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stop_c     = (state_q == STOP) && fall;
    frame_good = dat && odd_parity_ok(sr, par_q);
    accept_c   = stop_c && frame_good;
    reject_c   = (stop_c && !frame_good) || timeout_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      tmr     <= TLOAD;
    end else begin
      if (state_q == IDLE || fall) tmr <= TLOAD;
      else if (tmr != '0)          tmr <= tmr - TW'(1);

      if (fall) begin
        case (state_q)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            sr      <= {dat, sr[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BW'(1);
          end
          PARITY:  par_q <= dat;
          default: ;
        endcase
      end
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycode_q     <= 8'h00;
      code_valid_q  <= 1'b0;
      key_release_q <= 1'b0;
      frame_err_q   <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      code_valid_q  <= 1'b0;
      key_release_q <= 1'b0;
      frame_err_q   <= reject_c;
      if (reject_c) begin
        break_pending <= 1'b0;
      end else if (accept_c) begin
        if (sr == PS2_BREAK) begin
          break_pending <= 1'b1;
        end else begin
          keycode_q     <= sr;
          code_valid_q  <= 1'b1;
          key_release_q <= break_pending;
          break_pending <= 1'b0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycode_q    <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= accept_c;
      frame_err_q  <= reject_c;
      if (accept_c) keycode_q <= sr;
    end
  end

  assign key_release_q = 1'b0;
`endif

  assign bus.keycode     = keycode_q;
  assign bus.code_valid  = code_valid_q;
  assign bus.key_release = key_release_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = (state_q != IDLE);

endmodule
